// File: rtl/dw_shftreg_pkg.sv
// Shared encodings for the burst shift register: fill modes, shift
// directions and the burst engine state type.
package dw_shftreg_pkg;

    localparam logic [1:0] MODE_FILL = 2'b00;
    localparam logic [1:0] MODE_ROT  = 2'b01;
    localparam logic [1:0] MODE_REP  = 2'b10;
    localparam logic [1:0] MODE_ZERO = 2'b11;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/dw_shftreg_next.sv
// Combinational next-vector generator: one shift step of the whole
// register in the requested direction, with the entering stage chosen
// by the fill mode.
module dw_shftreg_next
    import dw_shftreg_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int LENGTH = 6
) (
    input  logic [LENGTH*WIDTH-1:0] i_cur,
    input  logic [WIDTH-1:0]        i_s_in,
    input  logic                    i_dir,
    input  logic [1:0]              i_mode,
    output logic [LENGTH*WIDTH-1:0] o_next
);

    logic [WIDTH-1:0] w_fill;
    logic [WIDTH-1:0] w_top;
    logic [WIDTH-1:0] w_bot;

    assign w_top = i_cur[(LENGTH-1)*WIDTH +: WIDTH];
    assign w_bot = i_cur[0 +: WIDTH];

    // Select the value entering the vacated end stage, then shift.
    always_comb begin
        w_fill = '0;
        o_next = i_cur;
        case (i_mode)
            MODE_FILL: w_fill = i_s_in;
            // Rotate brings the exiting stage back in at the other end.
            MODE_ROT:  w_fill = (i_dir == DIR_DN) ? w_bot : w_top;
            // Replicate keeps the entering-end stage as it is.
            MODE_REP:  w_fill = (i_dir == DIR_DN) ? w_top : w_bot;
            default:   w_fill = '0;
        endcase
        if (i_dir == DIR_UP)
            o_next = {i_cur[(LENGTH-1)*WIDTH-1:0], w_fill};
        else
            o_next = {w_fill, i_cur[LENGTH*WIDTH-1:WIDTH]};
    end

endmodule

// File: rtl/dw_shftreg_burst.sv
// Multi-lane bidirectional shift register with parallel load, single-step
// shift and an autonomous N-shift burst engine with busy/done handshake.
module dw_shftreg_burst
    import dw_shftreg_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int LENGTH = 6,
    parameter int CNT_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH-1:0]        s_in,
    input  logic [LENGTH*WIDTH-1:0] p_in,
    input  logic                    load_n,
    input  logic                    shift_n,
    input  logic                    dir,
    input  logic [1:0]              mode,
    input  logic                    burst_start,
    input  logic [CNT_W-1:0]        burst_len,
    output logic                    busy,
    output logic                    done,
    output logic [LENGTH*WIDTH-1:0] p_out,
    output logic [WIDTH-1:0]        s_out
);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic                    r_dir;
    logic [1:0]              r_mode;
    logic                    r_done;
    logic                    w_done_nxt;
    logic                    w_latch;
    logic [LENGTH*WIDTH-1:0] r_data;
    logic [LENGTH*WIDTH-1:0] w_next;
    logic                    w_dir_sel;
    logic [1:0]              w_mode_sel;
    logic                    w_single;

    // A running burst uses the settings captured at start; otherwise live inputs.
    assign w_dir_sel  = (r_state == RUN) ? r_dir  : dir;
    assign w_mode_sel = (r_state == RUN) ? r_mode : mode;

    // Single-step shift only when idle and no burst request competes for the edge.
    assign w_single = (r_state == IDLE) && !shift_n && !burst_start;

    dw_shftreg_next #(
        .WIDTH  (WIDTH),
        .LENGTH (LENGTH)
    ) u_next (
        .i_cur  (r_data),
        .i_s_in (s_in),
        .i_dir  (w_dir_sel),
        .i_mode (w_mode_sel),
        .o_next (w_next)
    );

    // Burst engine next-state, counter and done-pulse logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        w_latch     = 1'b0;
        case (r_state)
            IDLE: begin
                if (load_n && burst_start) begin
                    if (burst_len != '0) begin
                        w_state_nxt = RUN;
                        w_cnt_nxt   = burst_len;
                        w_latch     = 1'b1;
                    end else begin
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (!load_n) begin
                    // Parallel load aborts the burst silently.
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Burst engine state, counter, latched settings and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_dir   <= DIR_UP;
            r_mode  <= MODE_FILL;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
            if (w_latch) begin
                r_dir  <= dir;
                r_mode <= mode;
            end
        end
    end

    // Register contents: load beats burst shift beats single shift beats hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else if (!load_n) begin
            r_data <= p_in;
        end else if (r_state == RUN) begin
            r_data <= w_next;
        end else if (w_single) begin
            r_data <= w_next;
        end
    end

    assign busy  = (r_state == RUN);
    assign done  = r_done;
    assign p_out = r_data;
    // Exit stage follows the live dir input, even mid-burst.
    assign s_out = (dir == DIR_DN) ? r_data[0 +: WIDTH]
                                   : r_data[(LENGTH-1)*WIDTH +: WIDTH];

endmodule

// File: tb/tb_dw_shftreg_burst.sv
// Directed-vector bench for dw_shftreg_burst with WIDTH=8, LENGTH=4.
module tb_dw_shftreg_burst;

    localparam int WIDTH  = 8;
    localparam int LENGTH = 4;
    localparam int CNT_W  = 4;

    logic                    clk;
    logic                    rst_n;
    logic [WIDTH-1:0]        s_in;
    logic [LENGTH*WIDTH-1:0] p_in;
    logic                    load_n;
    logic                    shift_n;
    logic                    dir;
    logic [1:0]              mode;
    logic                    burst_start;
    logic [CNT_W-1:0]        burst_len;
    logic                    busy;
    logic                    done;
    logic [LENGTH*WIDTH-1:0] p_out;
    logic [WIDTH-1:0]        s_out;

    int n_chk;
    int n_err;
    int busy_cnt;
    int done_cnt;

    dw_shftreg_burst #(
        .WIDTH  (WIDTH),
        .LENGTH (LENGTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_in        (s_in),
        .p_in        (p_in),
        .load_n      (load_n),
        .shift_n     (shift_n),
        .dir         (dir),
        .mode        (mode),
        .burst_start (burst_start),
        .burst_len   (burst_len),
        .busy        (busy),
        .done        (done),
        .p_out       (p_out),
        .s_out       (s_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [31:0] val);
        p_in   = val;
        load_n = 1'b0;
        tick();
        load_n = 1'b1;
    endtask

    task automatic start_burst(input logic [CNT_W-1:0] len, input logic d, input logic [1:0] m);
        burst_len   = len;
        dir         = d;
        mode        = m;
        burst_start = 1'b1;
        tick();
        burst_start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_err = 0;
        rst_n = 1'b0; s_in = '0; p_in = '0; load_n = 1'b1; shift_n = 1'b1;
        dir = 1'b0; mode = 2'b00; burst_start = 1'b0; burst_len = '0;
        #2;
        chk("rst_pout", p_out, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        #10 rst_n = 1'b1;
        tick();

        // Load then single shifts
        do_load(32'h44332211);
        chk("load", p_out, 32'h44332211);
        shift_n = 1'b0; dir = 1'b0; mode = 2'b00; s_in = 8'hAA;
        tick();
        shift_n = 1'b1;
        chk("shift_up_fill", p_out, 32'h332211AA);
        chk("sout_up", {24'b0, s_out}, 32'h33);
        dir = 1'b1; mode = 2'b11; shift_n = 1'b0;
        tick();
        shift_n = 1'b1;
        chk("shift_dn_zero", p_out, 32'h00332211);
        chk("sout_dn", {24'b0, s_out}, 32'h11);

        // Burst rotate, len 5, with shift_n held low
        do_load(32'h44332211);
        shift_n = 1'b0;
        start_burst(4'd5, 1'b0, 2'b01);
        chk("rot_no_shift_on_start", p_out, 32'h44332211);
        busy_cnt = busy ? 1 : 0;
        done_cnt = done ? 1 : 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            busy_cnt += busy ? 1 : 0;
            done_cnt += done ? 1 : 0;
        end
        chk("rot_busy_cycles", busy_cnt, 32'd5);
        chk("rot_done_pulses", done_cnt, 32'd1);
        chk("rot_done_last", {31'b0, done}, 32'h1);
        chk("rot_result", p_out, 32'h33221144);
        shift_n = 1'b1;
        tick();
        chk("rot_done_drop", {31'b0, done}, 32'h0);
        chk("rot_hold", p_out, 32'h33221144);

        // Zero-length burst
        start_burst(4'd0, 1'b0, 2'b01);
        chk("zero_done", {31'b0, done}, 32'h1);
        chk("zero_busy", {31'b0, busy}, 32'h0);
        chk("zero_pout", p_out, 32'h33221144);
        tick();
        chk("zero_done_drop", {31'b0, done}, 32'h0);
        chk("zero_busy2", {31'b0, busy}, 32'h0);

        // Burst start together with load: load wins
        p_in = 32'h0A0B0C0D; load_n = 1'b0;
        start_burst(4'd3, 1'b0, 2'b01);
        load_n = 1'b1;
        chk("ldburst_busy", {31'b0, busy}, 32'h0);
        chk("ldburst_pout", p_out, 32'h0A0B0C0D);

        // Abort on second RUN cycle
        do_load(32'h44332211);
        start_burst(4'd3, 1'b0, 2'b01);
        tick();
        chk("abort_first_shift", p_out, 32'h33221144);
        p_in = 32'hDEADBEEF; load_n = 1'b0;
        tick();
        load_n = 1'b1;
        chk("abort_pout", p_out, 32'hDEADBEEF);
        chk("abort_busy", {31'b0, busy}, 32'h0);
        chk("abort_done", {31'b0, done}, 32'h0);
        tick();
        chk("abort_done2", {31'b0, done}, 32'h0);
        chk("abort_hold", p_out, 32'hDEADBEEF);
        start_burst(4'd1, 1'b0, 2'b11);
        chk("after_abort_busy", {31'b0, busy}, 32'h1);
        tick();
        chk("after_abort_done", {31'b0, done}, 32'h1);
        chk("after_abort_pout", p_out, 32'hADBEEF00);
        chk("after_abort_idle", {31'b0, busy}, 32'h0);

        // Replicate down with input toggles mid-burst
        do_load(32'h44332211);
        start_burst(4'd2, 1'b1, 2'b10);
        dir = 1'b0; mode = 2'b00; s_in = 8'h55;
        tick();
        chk("rep_mid", p_out, 32'h44443322);
        dir = 1'b1; mode = 2'b11;
        tick();
        chk("rep_result", p_out, 32'h44444433);
        chk("rep_done", {31'b0, done}, 32'h1);
        chk("rep_sout_dn", {24'b0, s_out}, 32'h33);
        dir = 1'b0;
        #1;
        chk("rep_sout_up", {24'b0, s_out}, 32'h44);

        // Asynchronous reset mid-burst
        start_burst(4'd5, 1'b0, 2'b01);
        tick();
        #3 rst_n = 1'b0;
        #1;
        chk("arst_pout", p_out, 32'h0);
        chk("arst_busy", {31'b0, busy}, 32'h0);
        chk("arst_done", {31'b0, done}, 32'h0);
        #2 rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_pout", p_out, 32'h0);
        chk("post_rst_busy", {31'b0, busy}, 32'h0);
        chk("post_rst_done", {31'b0, done}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/dw_shftreg_burst.md
Name: dw_shftreg_burst

Overview:
Multi-lane, bidirectional shift register with parallel load and an autonomous burst-shift engine. It is the parametrised successor of the single-bit serial/parallel shift register.
- Each of LENGTH stages holds WIDTH bits.
- Shifts toward either end, with four fill modes.
- Can perform N consecutive shifts from a single start pulse, with a busy/done handshake.
- Used in serialisers, delay lines and barrel-style alignment paths in the datapath.

Parameters:
WIDTH, 8, bits per stage (>=1)
LENGTH, 6, number of stages (>=2)
CNT_W, 4, width of burst_len; max burst = 2^CNT_W-1 shifts

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
s_in  in  WIDTH  serial stage input, used in fill mode 00
p_in  in  LENGTH*WIDTH  parallel load data; stage i = p_in[i*WIDTH +: WIDTH]
load_n  in  1  active-low synchronous parallel load
shift_n  in  1  active-low single-step shift enable
dir  in  1  0 = shift up (stage i -> i+1), 1 = shift down (stage i+1 -> i)
mode  in  2  00 fill s_in, 01 rotate, 10 replicate edge stage, 11 zero fill
burst_start  in  1  start pulse for a burst of burst_len shifts
burst_len  in  CNT_W  number of shifts in the burst
busy  out  1  burst in progress
done  out  1  one-cycle pulse after the last shift of a burst
p_out  out  LENGTH*WIDTH  register contents
s_out  out  WIDTH  exit stage: stage LENGTH-1 if dir=0, stage 0 if dir=1 (combinational on live dir)

Behaviour:
- Reset (async, rst_n low): p_out=0, busy=0, done=0, FSM=IDLE, count=0, latched dir/mode=0.
- Next-value rule for dir=0:
  - stage[i+1] <= stage[i].
  - Entering stage 0 is: s_in (00), stage[LENGTH-1] (01), stage[0] (10), 0 (11).
- dir=1 mirrors this: the entering stage is LENGTH-1; rotate takes stage[0]; replicate keeps stage[LENGTH-1].
- Priority at each edge: load_n=0 > burst RUN shift > shift_n=0 > hold.
- load_n=0: p_out <= p_in. If in RUN, the burst is aborted: FSM -> IDLE, busy=0, no done pulse.
- shift_n=0 in IDLE with load_n=1: one shift using live dir/mode. Ignored while busy.
- FSM states: IDLE, RUN.
- IDLE, burst_start=1, load_n=1, burst_len>0:
  - latch dir/mode; count <= burst_len; -> RUN; busy=1 from the next cycle.
  - No shift on the start edge.
  - A shift_n=0 on that same edge is ignored.
- IDLE, burst_start=1, burst_len=0: no shift; done=1 for the next cycle; stay IDLE.
- RUN: every edge performs one shift with the latched dir/mode and decrements count.
  - On the edge where count==1: -> IDLE, busy=0, done=1 for one cycle.
- Latency: burst_start at edge k gives shifts at edges k+1..k+N; busy is high after edges k..k+N-1; done is high after edge k+N.
- burst_start while busy is ignored.
- burst_start together with load_n=0: load wins, no burst.
- burst_len > LENGTH is legal. Rotate wraps modulo LENGTH; fill modes saturate to full fill.
- Input changes on dir/mode mid-burst do not affect the burst; they do affect s_out immediately.

Decomposition:
- Package dw_shftreg_pkg holds:
  - mode encodings: MODE_FILL=2'b00, MODE_ROT=2'b01, MODE_REP=2'b10, MODE_ZERO=2'b11
  - DIR_UP=0, DIR_DN=1
  - FSM state encoding: IDLE=1'b0, RUN=1'b1
- One combinational sub-module, dw_shftreg_next.
  - Inputs: current vector, s_in, dir, mode. Output: next vector.
  - The top instantiates it once and muxes the dir/mode source (live vs latched) by FSM state.

Test Plan:
- Setup for all: WIDTH=8, LENGTH=4.
- Reset: rst_n low mid-burst (async) -> p_out=0, busy=0, done=0 immediately. With no stimulus after release, outputs stay 0.
- Load then single shifts:
  - load p_in=0x44332211, then shift_n=0, dir=0, mode=00, s_in=0xAA for one cycle -> p_out=0x332211AA, s_out=0x33.
  - Then dir=1, mode=11 -> p_out=0x00332211.
- Burst rotate: p_out=0x44332211, burst_start with len=5, dir=0, mode=01:
  - busy high for 5 cycles, done pulses once, p_out=0x33221144.
  - shift_n=0 held throughout causes no extra shift.
- Burst zero length: burst_start, len=0 -> done pulse next cycle, busy never high, p_out unchanged.
- Abort: burst len=3, load_n=0 on second RUN cycle with p_in=0xDEADBEEF -> p_out=0xDEADBEEF, busy=0 next cycle, no done pulse. A following burst_start is accepted.
- Replicate and latching: p_out=0x44332211, burst len=2, dir=1, mode=10; toggle dir/mode inputs mid-burst -> p_out=0x44444433, unaffected by the toggles.
